krnl_partialknn_local_mem_1r1w_banked: RTL and testbench
========================================================

# krnl_partialKnn_local_mem_1r1w_banked

Parametrised local scratch memory for the partialKnn wrapper kernels, successor to the single-port URAM wrapper. It provides true one-read/one-write operation, a configurable pipelined read latency, byte-enabled writes, depth split across power-of-two banks, a selectable read/write collision policy and sticky error/collision status. It sits between the HLS-generated kernel datapath and URAM/BRAM storage and is instantiated once per local distance/feature buffer.

## Interface
- DATA_WIDTH, 256: word width in bits; multiple of 8.
- ADDR_WIDTH, 11: address width in bits.
- DEPTH, 2048: number of words; must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH.
- NUM_BANKS, 1: power of two, 1..8; must divide DEPTH. Bank = addr / (DEPTH/NUM_BANKS).
- READ_LATENCY, 2: cycles from read issue to data; legal range 1..4.
- COLLISION_MODE, 0: 0 = read-first (old data); 1 = write-first (byte-merged new data).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rd_ce  in  1  read issue strobe.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_valid  out  1  rd_data holds the result of a read issued READ_LATENCY cycles earlier.
- rd_data  out  DATA_WIDTH  read data.
- wr_ce  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers d[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- err_oob  out  1  sticky; set by any rd_ce or wr_ce with address >= DEPTH.
- collision_cnt  out  16  saturating count of same-address read/write in the same cycle.

## Operation
- Storage: NUM_BANKS arrays of DEPTH/NUM_BANKS words. Only the addressed bank is enabled per access; the others see ce=0.
- Write: when wr_ce=1 and reset=1 and wr_addr < DEPTH, write only bytes with wr_be[i]=1. wr_be=0 is a legal no-op write and does not count as a write for collisions.
- Out-of-range write: no storage change; sets err_oob.
- Read: when rd_ce=1, the word is looked up and shifted through a READ_LATENCY-stage valid/data pipeline. The bank-select index is pipelined alongside it to drive the output mux.
- Out-of-range read: returns all-zero data with rd_valid=1; sets err_oob.
- Cycles without rd_ce inject a bubble (valid=0). rd_data holds its last value while rd_valid=0.
- Collision (rd_ce and wr_ce both 1, rd_addr==wr_addr < DEPTH, wr_be != 0):
  - Mode 0 returns the pre-write word.
  - Mode 1 returns the pre-write word with the enabled bytes replaced by wr_data.
  - Both modes increment collision_cnt, saturating at 16'hFFFF.
- A read issued the cycle after a write to the same address returns the new data in both modes.
- Reset (reset=0):
  - Clears all pipeline valid bits, rd_valid=0, rd_data=0, err_oob=0, collision_cnt=0.
  - Memory contents are not cleared.
  - Reads and writes presented during reset are ignored.
  - Reads in flight when reset asserts are dropped and never produce rd_valid.
- No backpressure: the pipeline advances every cycle.

## Timing
- Read issued at edge t appears on rd_data/rd_valid after edge t+READ_LATENCY and is held for exactly one cycle unless the next read follows.
- The final pipeline stage is a register, so rd_data comes straight from a flop.
- Throughput: one read and one write per cycle, sustained, to any banks.
- Write commits at the edge where wr_ce=1.
- err_oob rises the cycle after the offending access.
- collision_cnt updates the cycle after the collision.
- Reset outputs: rd_valid=0, rd_data=0, err_oob=0, collision_cnt=0, all visible after the first clocked edge with reset=0.
- After reset deasserts, the first rd_valid can appear no earlier than READ_LATENCY cycles after the first accepted rd_ce.

## Test plan
- Write/read-back, READ_LATENCY=2, NUM_BANKS=4:
  - Write addr 0x000, 0x200, 0x400, 0x7FF with distinct patterns, wr_be all ones.
  - Read each back-to-back -> data appears 2 cycles after each rd_ce, rd_valid high 4 consecutive cycles, values match.
- Byte enables:
  - Write 0xFF..FF to addr 5, then write 0x00..00 with wr_be=32'h0000_000F.
  - Read -> low 4 bytes 0x00, rest 0xFF.
- Collision in both modes:
  - Addr 9 holds A. Same cycle: rd_ce and wr_ce to addr 9 with data B, full be.
  - Mode 0 returns A, mode 1 returns B; collision_cnt=1. A read the next cycle returns B.
- Out of range, DEPTH=1500:
  - Write to addr 1600 -> err_oob=1 next cycle, no memory change (addr 1600-1024 also unchanged).
  - Read addr 1600 -> rd_valid=1, rd_data=0.
- Reset mid-operation, READ_LATENCY=4:
  - Issue 3 reads, assert reset=0 for 1 cycle on the edge after the third read.
  - -> no rd_valid for the dropped reads, err_oob/collision_cnt=0, earlier written data still readable.
- Saturation: force 65540 collisions -> collision_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/krnl_partialknn_local_mem_1r1w_banked_if.sv
// rtl/krnl_partialknn_local_mem_1r1w_banked_if.sv - read/write port bundle for the banked 1R1W local memory
interface krnl_partialknn_local_mem_1r1w_banked_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 11
);
  logic                    rd_ce;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_ce;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;

  modport master (
    output rd_ce, rd_addr, wr_ce, wr_addr, wr_be, wr_data,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rd_ce, rd_addr, wr_ce, wr_addr, wr_be, wr_data,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/krnl_partialknn_local_mem_1r1w_banked.sv
// rtl/krnl_partialknn_local_mem_1r1w_banked.sv - banked 1R1W scratch memory with pipelined reads and collision status
module krnl_partialknn_local_mem_1r1w_banked #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 11,
  parameter int DEPTH          = 2048,
  parameter int NUM_BANKS      = 1,
  parameter int READ_LATENCY   = 2,
  parameter int COLLISION_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  krnl_partialknn_local_mem_1r1w_banked_if.slave bus,
  output logic        err_oob,
  output logic [15:0] collision_cnt
);
  localparam int NB         = DATA_WIDTH / 8;
  localparam int BANK_DEPTH = DEPTH / NUM_BANKS;
  localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LW         = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic          rd_oob, wr_oob, rd_ok, wr_ok, coll;
  logic [BW-1:0] rd_bank, wr_bank;
  logic [LW-1:0] rd_local, wr_local;

  assign rd_oob   = {1'b0, bus.rd_addr} >= DEPTH_W;
  assign wr_oob   = {1'b0, bus.wr_addr} >= DEPTH_W;
  assign rd_ok    = reset && bus.rd_ce && !rd_oob;
  assign wr_ok    = reset && bus.wr_ce && !wr_oob;
  assign coll     = rd_ok && wr_ok && (bus.rd_addr == bus.wr_addr) && (|bus.wr_be);
  assign rd_bank  = BW'(32'(bus.rd_addr) / BANK_DEPTH);
  assign wr_bank  = BW'(32'(bus.wr_addr) / BANK_DEPTH);
  assign rd_local = LW'(32'(bus.rd_addr) % BANK_DEPTH);
  assign wr_local = LW'(32'(bus.wr_addr) % BANK_DEPTH);

  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_q;

  // Each bank's read register samples before the same-edge write lands, giving read-first data.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] q;
    logic                  rd_en, wr_en;

    assign rd_en = rd_ok && (rd_bank == BW'(b));
    assign wr_en = wr_ok && (wr_bank == BW'(b));

    always_ff @(posedge clk) begin
      if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wr_be[i]) mem[wr_local][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
      if (rd_en) q <= mem[rd_local];
    end

    assign bank_q[b*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  logic                  s0_valid, s0_oob, s0_coll;
  logic [BW-1:0]         s0_bank;
  logic [NB-1:0]         s0_be;
  logic [DATA_WIDTH-1:0] s0_wdata, s0_word;
  logic [READ_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  // Bank mux plus write-first byte merge, between the bank register and the first pipeline flop.
  always_comb begin
    s0_word = bank_q[s0_bank*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < NB; i++) begin
      if (COLLISION_MODE == 1 && s0_coll && s0_be[i]) s0_word[8*i +: 8] = s0_wdata[8*i +: 8];
    end
    if (s0_oob) s0_word = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0_valid      <= 1'b0;
      pv            <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
      err_oob       <= 1'b0;
      collision_cnt <= '0;
    end else begin
      s0_valid <= bus.rd_ce;
      s0_oob   <= rd_oob;
      s0_bank  <= rd_bank;
      s0_coll  <= coll;
      s0_be    <= bus.wr_be;
      s0_wdata <= bus.wr_data;
      pv[0]    <= s0_valid;
      if (s0_valid) pd[0] <= s0_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      if ((bus.rd_ce && rd_oob) || (bus.wr_ce && wr_oob)) err_oob <= 1'b1;
      if (coll && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
    end
  end

  assign bus.rd_valid = pv[READ_LATENCY-1];
  assign bus.rd_data  = pd[READ_LATENCY-1];
endmodule

// File: tb/tb_krnl_partialknn_local_mem_1r1w_banked.sv
// tb/tb_krnl_partialknn_local_mem_1r1w_banked.sv - directed vector bench for the banked 1R1W local memory
module tb_krnl_partialknn_local_mem_1r1w_banked;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam logic [DW/8-1:0] BE_ALL = '1;
  localparam logic [DW/8-1:0] BE_LO4 = 32'h0000_000F;
  localparam logic [DW-1:0]   Z      = '0;
  localparam logic [DW-1:0]   ONES   = '1;
  localparam logic [DW-1:0]   LO_CLR = {{(DW-32){1'b1}}, 32'h0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        err_a, err_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  krnl_partialknn_local_mem_1r1w_banked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  krnl_partialknn_local_mem_1r1w_banked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  krnl_partialknn_local_mem_1r1w_banked #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(2048), .NUM_BANKS(4),
    .READ_LATENCY(2), .COLLISION_MODE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .err_oob(err_a), .collision_cnt(cnt_a)
  );

  krnl_partialknn_local_mem_1r1w_banked #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1500), .NUM_BANKS(4),
    .READ_LATENCY(4), .COLLISION_MODE(1)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .err_oob(err_b), .collision_cnt(cnt_b)
  );

  typedef struct {
    bit              sel;
    bit              rce;
    logic [AW-1:0]   raddr;
    bit              wce;
    logic [AW-1:0]   waddr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    bit              ev;
    logic [DW-1:0]   ed;
    logic [15:0]     ec;
    bit              ee;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [DW-1:0] pat(int k);
    logic [DW-1:0] p;
    for (int i = 0; i < DW/32; i++) p[32*i +: 32] = 32'h5A5A_0000 + 32'(k) * 32'h0001_0101 + 32'(i) * 32'h0100_0011;
    return p;
  endfunction

  function automatic vec_t mk(bit sel, bit rce, int ra, bit wce, int wa, logic [DW/8-1:0] be,
                              logic [DW-1:0] wd, bit ev, logic [DW-1:0] ed, int ec, bit ee);
    vec_t v;
    v.sel = sel; v.rce = rce; v.raddr = AW'(ra); v.wce = wce; v.waddr = AW'(wa);
    v.be = be; v.wdata = wd; v.ev = ev; v.ed = ed; v.ec = 16'(ec); v.ee = ee;
    return v;
  endfunction

  task automatic drive(bit sel, bit rce, int ra, bit wce, int wa, logic [DW/8-1:0] be, logic [DW-1:0] wd);
    ifa.rd_ce = 1'b0; ifa.wr_ce = 1'b0; ifb.rd_ce = 1'b0; ifb.wr_ce = 1'b0;
    if (!sel) begin
      ifa.rd_ce = rce; ifa.rd_addr = AW'(ra); ifa.wr_ce = wce; ifa.wr_addr = AW'(wa);
      ifa.wr_be = be;  ifa.wr_data = wd;
    end else begin
      ifb.rd_ce = rce; ifb.rd_addr = AW'(ra); ifb.wr_ce = wce; ifb.wr_addr = AW'(wa);
      ifb.wr_be = be;  ifb.wr_data = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, Z);
  endtask

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial begin
    ifa.rd_addr = '0; ifa.wr_addr = '0; ifa.wr_be = '0; ifa.wr_data = '0;
    ifb.rd_addr = '0; ifb.wr_addr = '0; ifb.wr_be = '0; ifb.wr_data = '0;

    // DUT A: L=2, 4 banks of 512, read-first
    tv.push_back(mk(0, 0, 0,     1, 'h000, BE_ALL, pat(0), 0, Z,       0, 0));
    tv.push_back(mk(0, 0, 0,     1, 'h200, BE_ALL, pat(1), 0, Z,       0, 0));
    tv.push_back(mk(0, 0, 0,     1, 'h400, BE_ALL, pat(2), 0, Z,       0, 0));
    tv.push_back(mk(0, 0, 0,     1, 'h7FF, BE_ALL, pat(3), 0, Z,       0, 0));
    tv.push_back(mk(0, 1, 'h000, 0, 0,     '0,     Z,      0, Z,       0, 0));
    tv.push_back(mk(0, 1, 'h200, 0, 0,     '0,     Z,      0, Z,       0, 0));
    tv.push_back(mk(0, 1, 'h400, 0, 0,     '0,     Z,      1, pat(0),  0, 0));
    tv.push_back(mk(0, 1, 'h7FF, 0, 0,     '0,     Z,      1, pat(1),  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, pat(2),  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, pat(3),  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      0, pat(3),  0, 0));
    tv.push_back(mk(0, 0, 0,     1, 5,     BE_ALL, ONES,   0, pat(3),  0, 0));
    tv.push_back(mk(0, 0, 0,     1, 5,     BE_LO4, Z,      0, pat(3),  0, 0));
    tv.push_back(mk(0, 1, 5,     0, 0,     '0,     Z,      0, pat(3),  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      0, pat(3),  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, LO_CLR,  0, 0));
    tv.push_back(mk(0, 1, 5,     1, 5,     '0,     Z,      0, LO_CLR,  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      0, LO_CLR,  0, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, LO_CLR,  0, 0));
    tv.push_back(mk(0, 0, 0,     1, 9,     BE_ALL, pat(10),0, LO_CLR,  0, 0));
    tv.push_back(mk(0, 1, 9,     1, 9,     BE_ALL, pat(11),0, LO_CLR,  1, 0));
    tv.push_back(mk(0, 1, 9,     0, 0,     '0,     Z,      0, LO_CLR,  1, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, pat(10), 1, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      1, pat(11), 1, 0));
    tv.push_back(mk(0, 0, 0,     0, 0,     '0,     Z,      0, pat(11), 1, 0));
    // DUT B: L=4, DEPTH=1500 over 4 banks of 375, write-first
    tv.push_back(mk(1, 0, 0,     1, 9,     BE_ALL, pat(10),0, Z,       0, 0));
    tv.push_back(mk(1, 0, 0,     1, 576,   BE_ALL, pat(20),0, Z,       0, 0));
    tv.push_back(mk(1, 0, 0,     1, 100,   BE_ALL, pat(21),0, Z,       0, 0));
    tv.push_back(mk(1, 1, 9,     1, 9,     BE_ALL, pat(11),0, Z,       1, 0));
    tv.push_back(mk(1, 1, 9,     0, 0,     '0,     Z,      0, Z,       1, 0));
    tv.push_back(mk(1, 0, 0,     1, 1600,  BE_ALL, pat(22),0, Z,       1, 1));
    tv.push_back(mk(1, 1, 1600,  0, 0,     '0,     Z,      0, Z,       1, 1));
    tv.push_back(mk(1, 1, 576,   0, 0,     '0,     Z,      1, pat(11), 1, 1));
    tv.push_back(mk(1, 1, 100,   0, 0,     '0,     Z,      1, pat(11), 1, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      0, pat(11), 1, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      1, Z,       1, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      1, pat(20), 1, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      1, pat(21), 1, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      0, pat(21), 1, 1));
    tv.push_back(mk(1, 1, 9,     1, 9,     BE_LO4, Z,      0, pat(21), 2, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      0, pat(21), 2, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      0, pat(21), 2, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      0, pat(21), 2, 1));
    tv.push_back(mk(1, 0, 0,     0, 0,     '0,     Z,      1, pat(11) & LO_CLR, 2, 1));

    idle();
    idle();
    check("reset a rd_valid", ifa.rd_valid, 0);
    check("reset a rd_data",  ifa.rd_data,  Z);
    check("reset a err_oob",  err_a, 0);
    check("reset a coll_cnt", cnt_a, 0);
    check("reset b rd_valid", ifb.rd_valid, 0);
    check("reset b rd_data",  ifb.rd_data,  Z);
    check("reset b err_oob",  err_b, 0);
    check("reset b coll_cnt", cnt_b, 0);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].sel, tv[i].rce, int'(tv[i].raddr), tv[i].wce, int'(tv[i].waddr), tv[i].be, tv[i].wdata);
      if (!tv[i].sel) begin
        check($sformatf("row%0d a rd_valid", i), ifa.rd_valid, tv[i].ev);
        check($sformatf("row%0d a rd_data", i),  ifa.rd_data,  tv[i].ed);
        check($sformatf("row%0d a coll_cnt", i), cnt_a, tv[i].ec);
        check($sformatf("row%0d a err_oob", i),  err_a, tv[i].ee);
      end else begin
        check($sformatf("row%0d b rd_valid", i), ifb.rd_valid, tv[i].ev);
        check($sformatf("row%0d b rd_data", i),  ifb.rd_data,  tv[i].ed);
        check($sformatf("row%0d b coll_cnt", i), cnt_b, tv[i].ec);
        check($sformatf("row%0d b err_oob", i),  err_b, tv[i].ee);
      end
    end

    // Reset lands on the edge after the third read; all three reads are dropped.
    drive(1, 1, 9,   0, 0, '0, Z);
    drive(1, 1, 576, 0, 0, '0, Z);
    drive(1, 1, 100, 0, 0, '0, Z);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    check("midrst b rd_data", ifb.rd_data, Z);
    check("midrst b err_oob", err_b, 0);
    check("midrst b coll_cnt", cnt_b, 0);
    check("midrst a coll_cnt", cnt_a, 0);
    for (int k = 0; k < 6; k++) begin
      idle();
      check($sformatf("midrst drop %0d rd_valid", k), ifb.rd_valid, 0);
    end
    drive(1, 1, 9,   0, 0, '0, Z);
    drive(1, 1, 576, 0, 0, '0, Z);
    idle();
    idle();
    check("postrst early rd_valid", ifb.rd_valid, 0);
    idle();
    check("postrst addr9 rd_valid", ifb.rd_valid, 1);
    check("postrst addr9 rd_data",  ifb.rd_data,  pat(11) & LO_CLR);
    idle();
    check("postrst addr576 rd_valid", ifb.rd_valid, 1);
    check("postrst addr576 rd_data",  ifb.rd_data,  pat(20));

    // Saturating collision counter on DUT A
    for (int k = 0; k < 3; k++) drive(0, 1, 9, 1, 9, BE_ALL, pat(12));
    check("sat coll_cnt after 3", cnt_a, 16'd3);
    repeat (65537) @(posedge clk);
    #1;
    idle();
    check("sat coll_cnt held", cnt_a, 16'hFFFF);
    idle();
    check("sat coll_cnt stays", cnt_a, 16'hFFFF);
    check("sat a err_oob", err_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
